uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive side of the UART link: consumes the serial line produced by UART_TX (TX_OUT -> RX_IN).
//  Oversamples RX_IN at Prescale x baud, majority-votes each bit, deserialises LSB first, checks
//  parity and stop, presents a parallel word with a one-cycle valid pulse. Frame = start(0), Data_width data, [parity], stop(1).
// PARAMETERS
//  Data_width  8  data bits per frame
// PORTS
//  CLK           in   1           oversampling clock, Prescale x baud; single clock domain
//  RST           in   1           asynchronous, active-low reset
//  RX_IN         in   1           serial line, idle high; already synchronised upstream
//  Prescale      in   6           oversampling ratio; legal 8, 16, 32; changed only while idle
//  PAR_EN        in   1           1 = parity bit present
//  PAR_TYP       in   1           0 = even, 1 = odd (same encoding as TX)
//  P_DATA        out  Data_width  last good received word
//  data_valid    out  1           one-cycle pulse: P_DATA updated this cycle
//  parity_error  out  1           one-cycle pulse: parity mismatch on the finished frame
//  stop_error    out  1           one-cycle pulse: stop bit sampled 0
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, edge_cnt = 0, bit_cnt = 0, shift register 0.
//  edge_cnt counts 0..Prescale-1 inside each bit, then wraps to 0 and advances the bit.
//  Sampling: RX_IN captured at edge_cnt = P/2-1, P/2, P/2+1; bit value = majority of the three.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE   : RX_IN == 0 -> START; the detection cycle counts as edge 0 (edge_cnt loads 1).
//   START  : at edge P-1: sampled bit 1 -> IDLE (glitch, no outputs); 0 -> DATA.
//   DATA   : shift sampled bit in LSB first; after bit Data_width-1 at edge P-1 -> PARITY if PAR_EN else STOP.
//   PARITY : store sampled bit; at edge P-1 -> STOP.
//   STOP   : at edge P-1 -> IDLE; outputs evaluated on that edge.
//  Outputs: registered, valid the cycle after the STOP edge P-1, high for exactly one cycle.
//   stop_error   = (stop sample == 0)
//   parity_error = PAR_EN && (rx parity != ^data XOR PAR_TYP)
//   data_valid   = !stop_error && !parity_error; only then is P_DATA loaded from the shift register.
//   On an error, P_DATA holds its previous value.
//  Latency: stop-bit last edge -> data_valid = 1 CLK. Frame length = (2 + Data_width + PAR_EN) x Prescale CLKs.
//  Back-to-back: a start bit immediately following the stop bit is accepted; IDLE is occupied for 1 cycle,
//   and that cycle counts as edge 0 of the new start bit.
//  Glitch on a data bit shorter than 2 samples at the sample window does not corrupt the bit (majority).
//  Prescale/PAR_EN change mid-frame: undefined; not required to be handled.
//  RST low mid-frame: immediate return to reset state; partial frame discarded; no pulses generated.
//  No output pulse is ever generated for an aborted (glitch) start.
// STRUCTURE
//  Shared header uart_defs.vh: FSM state encodings (3-bit), legal Prescale constants,
//   PAR_EVEN/PAR_ODD encodings (shared with UART_TX parity_calc).
//  Sub-module rx_data_sampler: edge_cnt compare + 3-sample majority vote, output sampled_bit.
//  uart_rx top holds the FSM, edge/bit counters, shift register, and parity/stop check and output registers.
// TESTING
//  1 Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0, stop 1 -> data_valid pulse at CLK 88+1,
//    P_DATA=0xA5, no errors.
//  2 As 1 but parity bit 1 -> parity_error pulse, data_valid stays 0, P_DATA keeps previous 0xA5.
//  3 Prescale=16, PAR_EN=0, 0x5A with stop bit 0 -> stop_error pulse only; P_DATA unchanged.
//  4 Prescale=16, RX_IN low for 3 cycles then high -> FSM returns to IDLE, no pulses;
//    next full frame 0x81 -> received correctly.
//  5 Prescale=32, PAR_EN=0, back-to-back 0x3C then 0xC3 with no idle gap, plus a 1-cycle glitch
//    at a bit centre -> two data_valid pulses 320 CLKs apart, values 0x3C and 0xC3.
//  6 RST low during DATA bit 4 -> all outputs 0 immediately, IDLE; following frame 0xFF
//    (PAR_EN=1, PAR_TYP=1, parity 1) -> valid, P_DATA=0xFF.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
// Contents: FSM state encoding (3-bit), parity-type encodings (the same as the
// TX parity_calc), and a 3-input majority helper used by the bit sampler.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Bit sampler for the UART receiver.
// The line is captured on three consecutive oversampling edges around the bit
// centre (P/2-1, P/2, P/2+1). The bit value is the majority of those three
// captures, so a glitch on one sample does not corrupt the bit.
// Ports:
//   clk_sys      oversampling clock
//   rst_b        asynchronous active-low reset
//   rx_in        serial line (already synchronised)
//   prescale     oversampling ratio (8/16/32)
//   edge_cnt     position inside the current bit (0..prescale-1)
//   sampled_bit  majority-voted bit value; stable from edge P/2+2 to the end of the bit
module uart_rx_data_sampler
   import uart_rx_pkg::*;
(
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic       rx_in,
   input  logic [5:0] prescale,
   input  logic [5:0] edge_cnt,
   output logic       sampled_bit
);

   logic [5:0] half;
   logic [2:0] samples;

   assign half = {1'b0, prescale[5:1]};

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         samples <= '0;
      end else if (edge_cnt == half - 6'd1) begin
         samples[0] <= rx_in;
      end else if (edge_cnt == half) begin
         samples[1] <= rx_in;
      end else if (edge_cnt == half + 6'd1) begin
         samples[2] <= rx_in;
      end
   end

   assign sampled_bit = majority3(samples[0], samples[1], samples[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver.
// The receiver oversamples RX_IN at Prescale x baud and majority-votes each bit.
// It deserialises the data LSB first and checks the optional parity bit and the
// stop bit. Results are presented as registered one-cycle pulses in the cycle
// after the last edge of the stop bit.
// Ports:
//   CLK           oversampling clock
//   RST           asynchronous active-low reset
//   RX_IN         serial line, idle high
//   Prescale      oversampling ratio (8/16/32); changed only while idle
//   PAR_EN        parity bit present
//   PAR_TYP       0 = even, 1 = odd
//   P_DATA        last good received word
//   data_valid    pulse: P_DATA updated
//   parity_error  pulse: parity mismatch on the finished frame
//   stop_error    pulse: stop bit sampled 0
//
// state  | meaning
// IDLE   | line idle; a low level starts a frame (that cycle counts as edge 0)
// START  | start bit; a high vote at its last edge means a glitch, so go back to IDLE
// DATA   | Data_width data bits shifted in LSB first
// PARITY | parity bit captured
// STOP   | stop bit; frame checked and outputs loaded at its last edge
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int Data_width = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [Data_width-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  parity_error,
   output logic                  stop_error
);

   localparam int BW = (Data_width > 1) ? $clog2(Data_width) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(Data_width - 1);

   rx_state_e             state, state_nxt;
   logic [5:0]            edge_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [Data_width-1:0] shift_reg;
   logic                  par_bit;
   logic                  sampled_bit;
   logic                  edge_last;
   logic                  frame_done;
   logic                  exp_par;
   logic                  stop_bad;
   logic                  par_bad;

   uart_rx_data_sampler u_sampler (
      .clk_sys     (CLK),
      .rst_b       (RST),
      .rx_in       (RX_IN),
      .prescale    (Prescale),
      .edge_cnt    (edge_cnt),
      .sampled_bit (sampled_bit)
   );

   assign edge_last = (edge_cnt == Prescale - 6'd1);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!RX_IN) state_nxt = ST_START;
         end
         ST_START: begin
            if (edge_last) state_nxt = sampled_bit ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (edge_last && (bit_cnt == BIT_LAST))
               state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (edge_last) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (edge_last) begin
               state_nxt  = ST_IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // In IDLE the detection cycle is edge 0 of the start bit, so the counter
   // loads 1 when the line is seen low.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt <= '0;
      end else if (state == ST_IDLE) begin
         edge_cnt <= RX_IN ? 6'd0 : 6'd1;
      end else if (edge_last) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt + 6'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
      end else begin
         if ((state == ST_DATA) && edge_last) begin
            shift_reg <= {sampled_bit, shift_reg[Data_width-1:1]};
            bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
         end
         if ((state == ST_PARITY) && edge_last) begin
            par_bit <= sampled_bit;
         end
      end
   end

   always_comb begin
      exp_par = 1'b0;
      case (PAR_TYP)
         PAR_EVEN: exp_par = ^shift_reg;
         PAR_ODD:  exp_par = ~^shift_reg;
         default:  exp_par = ^shift_reg;
      endcase
   end

   assign stop_bad = ~sampled_bit;
   assign par_bad  = PAR_EN & (par_bit != exp_par);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         P_DATA       <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
         if (frame_done) begin
            stop_error   <= stop_bad;
            parity_error <= par_bad;
            if (!stop_bad && !par_bad) begin
               data_valid <= 1'b1;
               P_DATA     <= shift_reg;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx;
   logic [5:0]    prescale;
   logic          par_en;
   logic          par_typ;
   logic [DW-1:0] p_data;
   logic          data_valid;
   logic          parity_error;
   logic          stop_error;

   int            checks = 0;
   int            errors = 0;
   int unsigned   cyc = 0;
   logic [DW-1:0] exp_pdata;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.Data_width(DW)) dut (
      .CLK          (clk),
      .RST          (rst_n),
      .RX_IN        (rx),
      .Prescale     (prescale),
      .PAR_EN       (par_en),
      .PAR_TYP      (par_typ),
      .P_DATA       (p_data),
      .data_valid   (data_valid),
      .parity_error (parity_error),
      .stop_error   (stop_error)
   );

   typedef struct {
      logic [5:0]    p;
      logic          pe;
      logic          pt;
      logic [DW-1:0] d;
      logic          par_flip;
      logic          sb;
      logic          ev;
      logic          eperr;
      logic          eserr;
      logic [DW-1:0] epd;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic good_par(input logic [DW-1:0] d, input logic pt);
      return (^d) ^ pt;
   endfunction

   // Drives one complete frame, one bit per Prescale clocks. It returns just
   // after the clock edge on which the result pulses must be visible.
   task automatic send_frame(input logic [5:0] p, input logic pe, input logic pt,
                             input logic [DW-1:0] d, input logic pb, input logic sb,
                             input int glitch_bit);
      logic bits[$];
      logic spur;
      int   n;
      spur     = 1'b0;
      prescale = p;
      par_en   = pe;
      par_typ  = pt;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (pe) bits.push_back(pb);
      bits.push_back(sb);
      n = bits.size();
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < int'(p); c++) begin
            rx = (b == glitch_bit && c == int'(p) / 2) ? ~bits[b] : bits[b];
            @(posedge clk); #1;
            if (!(b == n - 1 && c == int'(p) - 1) && (data_valid | parity_error | stop_error))
               spur = 1'b1;
         end
      end
      chk("no_early_pulse", {31'd0, spur}, 32'd0);
   endtask

   task automatic idle(input int n);
      logic spur;
      spur = 1'b0;
      rx   = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (data_valid | parity_error | stop_error) spur = 1'b1;
      end
      if (n > 0) chk("idle_no_pulse", {31'd0, spur}, 32'd0);
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic eperr,
                          input logic eserr, input logic [DW-1:0] epd);
      chk({tag, "_valid"}, {31'd0, data_valid}, {31'd0, ev});
      chk({tag, "_perr"}, {31'd0, parity_error}, {31'd0, eperr});
      chk({tag, "_serr"}, {31'd0, stop_error}, {31'd0, eserr});
      chk({tag, "_pdata"}, {24'd0, p_data}, {24'd0, epd});
   endtask

   initial begin
      logic [5:0]    p_r;
      logic          pe_r, pt_r, pb_r, sb_r, perr_m, serr_m, val_m;
      logic [DW-1:0] d_r;
      logic [5:0]    p_prev;
      logic          pe_prev, pt_prev;
      int            gap, gb;
      int unsigned   t1, t2;
      logic [DW-1:0] part;

      vecs[0] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
      vecs[1] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
      vecs[2] = '{6'd16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[3] = '{6'd8,  1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[4] = '{6'd16, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[5] = '{6'd32, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};

      rst_n    = 1'b1;
      rx       = 1'b1;
      prescale = 6'd8;
      par_en   = 1'b0;
      par_typ  = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      chk_out("reset", 1'b0, 1'b0, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_pdata = '0;

      // Directed frames
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d,
                    good_par(vecs[i].d, vecs[i].pt) ^ vecs[i].par_flip, vecs[i].sb, -1);
         chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eperr, vecs[i].eserr, vecs[i].epd);
         idle(2);
      end
      exp_pdata = 8'h00;

      // Short start glitch, then a normal frame
      prescale = 6'd16;
      par_en   = 1'b0;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(24);
      send_frame(6'd16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1);
      chk_out("after_glitch", 1'b1, 1'b0, 1'b0, 8'h81);
      idle(2);

      // Back-to-back frames with single-sample glitches at bit centres
      send_frame(6'd32, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 4);
      t1 = cyc;
      chk_out("b2b_first", 1'b1, 1'b0, 1'b0, 8'h3C);
      send_frame(6'd32, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 2);
      t2 = cyc;
      chk_out("b2b_second", 1'b1, 1'b0, 1'b0, 8'hC3);
      chk("b2b_spacing", t2 - t1, 32'd320);
      idle(2);

      // Reset during data bit 4
      prescale = 6'd8;
      par_en   = 1'b1;
      par_typ  = 1'b1;
      part     = 8'h5A;
      rx = 1'b0;
      repeat (8) @(posedge clk);
      for (int b = 0; b < 4; b++) begin
         #1 rx = part[b];
         repeat (8) @(posedge clk);
      end
      #1 rx = part[4];
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_out("mid_reset", 1'b0, 1'b0, 1'b0, 8'h00);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      idle(2);
      send_frame(6'd8, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, -1);
      chk_out("post_reset", 1'b1, 1'b0, 1'b0, 8'hFF);
      exp_pdata = 8'hFF;
      idle(2);

      // Random frames against the frame-level model
      p_prev = 6'd8; pe_prev = 1'b1; pt_prev = 1'b1;
      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 2))
            0: p_r = 6'd8;
            1: p_r = 6'd16;
            default: p_r = 6'd32;
         endcase
         pe_r = 1'($urandom_range(0, 1));
         pt_r = 1'($urandom_range(0, 1));
         d_r  = DW'($urandom);
         pb_r = good_par(d_r, pt_r) ^ ($urandom_range(0, 5) == 0);
         sb_r = ($urandom_range(0, 7) != 0);
         gb   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DW)) : -1;
         gap  = $urandom_range(0, 2);
         if ((p_r != p_prev || pe_r != pe_prev || pt_r != pt_prev) && gap == 0) gap = 1;
         idle(gap);

         serr_m = ~sb_r;
         perr_m = pe_r && (pb_r != good_par(d_r, pt_r));
         val_m  = !serr_m && !perr_m;
         if (val_m) exp_pdata = d_r;

         send_frame(p_r, pe_r, pt_r, d_r, pb_r, sb_r, gb);
         chk_out($sformatf("rnd%0d", k), val_m, perr_m, serr_m, exp_pdata);
         p_prev = p_r; pe_prev = pe_r; pt_prev = pt_r;
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
